render_frame_sched: RTL
=======================

// Module: render_frame_sched
// PURPOSE
// Per-frame scheduler for the 3D render pipeline (a3d_to_2d -> rasterize -> zbuffer -> color BRAM).
// Double-buffers the model color BRAM: display reads the front bank, the pipeline writes the back bank.
// At each vsync it swaps banks, clears the back bank to BG_COLOR and launches a render.
// Sole owner of the color BRAM write port: arbitrates between the clear engine and zbuffer writes.
// PARAMETERS
// DEPTH       4096    pixels per bank (64x64 model tile)
// ADDRW       12      pixel address width, log2(DEPTH)
// COLORW      10      color word width
// BG_COLOR    10'h200 clear value written to every back-bank entry
// QUIET_CYC   16      consecutive idle cycles that declare the render finished
// PORTS
// clk            in   1         pipeline clock (65 MHz domain)
// rst_n          in   1         asynchronous, active-low reset
// vsync_in       in   1         active-high vsync from vga; rising edge = frame boundary
// raster_busy_in in   1         rasterize busy_out
// pix_valid_in   in   1         zbuffer valid_out
// pix_addr_in    in   ADDRW     zbuffer pixel_addr
// pix_color_in   in   COLORW    zbuffer pixel_out
// render_start_out out 1        1-cycle start pulse to a3d_to_2d valid_in
// wr_en_out      out  1         BRAM port-A write enable
// wr_addr_out    out  ADDRW+1   {back_bank, pixel_addr}
// wr_data_out    out  COLORW    BRAM write data
// front_bank_out out  1         bank the display reads; MSB of display read address
// frame_done_out out  1         back bank complete and waiting for swap
// overrun_out    out  1         1-cycle pulse: vsync arrived before render finished
// frame_count_out out 16        frames swapped (RSCHED_STATS_EN only, else 0)
// drop_count_out out  16        dropped pixel writes (RSCHED_STATS_EN only, else 0)
// BEHAVIOUR
// - Reset (async, rst_n=0): state IDLE, every output 0, front_bank=0, counters 0. Takes effect immediately, including mid-CLEAR or mid-RENDER.
// - Edge detect: vsync_q is registered; edge = vsync_in & ~vsync_q.
// - IDLE: on edge -> CLEAR; no swap.
// - DONE: frame_done_out=1. On edge: toggle front_bank, frame_count++, -> CLEAR.
// - CLEAR: writes addr {~front_bank, 0..DEPTH-1}, data BG_COLOR, one per cycle, DEPTH cycles back-to-back, then -> LAUNCH.
// - LAUNCH: render_start_out=1 for exactly 1 cycle, clear quiet counter, -> RENDER.
// - RENDER: each pix_valid_in is forwarded one cycle later as a write to {~front_bank, pix_addr_in} with pix_color_in. Throughput: 1 write/cycle, no backpressure.
// - RENDER exit: quiet counter increments when raster_busy_in=0 and pix_valid_in=0, and is cleared otherwise. At QUIET_CYC -> DONE. An empty model therefore finishes QUIET_CYC cycles after LAUNCH.
// - All write-port outputs are registered. Clear and forward never overlap because only one state drives the port.
// - pix_valid_in outside RENDER: write dropped, drop_count++.
// - Edge in CLEAR/LAUNCH/RENDER: overrun_out pulses, no swap, current frame continues. The late frame then waits in DONE for the next edge.
// - Counters saturate at 16'hFFFF. front_bank is stable except at the DONE+edge clock.
// CONFIGURATION
// `RSCHED_STATS_EN defined: frame_count_out and drop_count_out are live counters as above.
// Not defined: both ports are tied to 16'h0 and the counter registers are not built. All other behaviour is identical.
// STRUCTURE
// render_pkg holds: ADDRW/COLORW/DEPTH localparams, BG_COLOR default, typedef logic [ADDRW-1:0] pix_addr_t, typedef logic [COLORW-1:0] color_t.
// The state enum (IDLE, CLEAR, LAUNCH, RENDER, DONE) is local to this module.
// Sub-module rsched_clear_gen: start/busy address counter emitting the DEPTH clear writes and a last flag.
// TESTING
// 1. Reset, then vsync edge -> 4096 writes addr 0x1000..0x1FFF data 0x200 on consecutive cycles. render_start_out is high for 1 cycle immediately after the last clear write.
// 2. RENDER, back=1, pix_valid with addr 0x123, color 0x3FF -> next cycle wr_en=1, wr_addr=0x1123, wr_data=0x3FF.
// 3. busy=0, no valid for 16 cycles -> frame_done_out=1. Next edge -> front_bank=1 and clear writes go to 0x0000..0x0FFF.
// 4. vsync edge during RENDER -> overrun_out pulses 1 cycle, front_bank unchanged, forwarding continues.
// 5. pix_valid during CLEAR (STATS on) -> no write leaks into the clear stream, drop_count_out=1.
// 6. rst_n low mid-CLEAR -> wr_en_out=0 asynchronously, front_bank=0, IDLE. After release, the sequence restarts cleanly at the next vsync.

Source files
------------

// File: rtl/render_pkg.sv
// Shared types and constants for the render-pipeline frame scheduler.
package render_pkg;

  localparam int unsigned DEPTH     = 4096;
  localparam int unsigned ADDRW     = 12;
  localparam int unsigned COLORW    = 10;
  localparam int unsigned QUIET_CYC = 16;
  localparam int unsigned QUIETW    = $clog2(QUIET_CYC + 1);
  localparam int unsigned STATW     = 16;

  typedef logic [ADDRW-1:0]  pix_addr_t;
  typedef logic [COLORW-1:0] color_t;

  localparam color_t BG_COLOR = COLORW'(10'h200);

  // Saturating increment for the statistics counters
  function automatic logic [STATW-1:0] sat_inc(input logic [STATW-1:0] v);
    return (v == {STATW{1'b1}}) ? v : v + STATW'(1);
  endfunction

endpackage

// File: rtl/rsched_clear_gen.sv
// Clear-address generator: after i_start, walks 0..DEPTH-1 one per cycle.
module rsched_clear_gen
  import render_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      i_start,
  output logic      o_busy,
  output pix_addr_t o_addr,
  output logic      o_last_c
);

  logic      r_busy;
  pix_addr_t r_addr;

  assign o_last_c = r_busy && (r_addr == ADDRW'(DEPTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_addr <= '0;
    end else if (i_start) begin
      r_busy <= 1'b1;
      r_addr <= '0;
    end else if (r_busy) begin
      if (o_last_c) begin
        r_busy <= 1'b0;
        r_addr <= '0;
      end else begin
        r_addr <= r_addr + ADDRW'(1);
      end
    end
  end

  assign o_busy = r_busy;
  assign o_addr = r_addr;

endmodule

// File: rtl/render_frame_sched.sv
// Per-frame scheduler: double-buffers the color BRAM, clears the back bank and launches renders.
// Optional statistics counters are built when RSCHED_STATS_EN is defined.
module render_frame_sched
  import render_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vsync_in,
  input  logic              raster_busy_in,
  input  logic              pix_valid_in,
  input  logic [ADDRW-1:0]  pix_addr_in,
  input  logic [COLORW-1:0] pix_color_in,
  output logic              render_start_out,
  output logic              wr_en_out,
  output logic [ADDRW:0]    wr_addr_out,
  output logic [COLORW-1:0] wr_data_out,
  output logic              front_bank_out,
  output logic              frame_done_out,
  output logic              overrun_out,
  output logic [STATW-1:0]  frame_count_out,
  output logic [STATW-1:0]  drop_count_out
);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_LAUNCH, S_RENDER, S_DONE} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_vsync_q;
  logic              w_edge;
  logic              w_clr_start;
  logic              w_clr_busy;
  logic              w_clr_last;
  pix_addr_t         w_clr_addr;
  logic              w_idle_pix;
  logic              w_swap;
  logic [QUIETW-1:0] r_quiet;
  logic              r_front_bank;
  logic              r_wr_en;
  logic [ADDRW:0]    r_wr_addr;
  color_t            r_wr_data;
  logic              r_render_start;
  logic              r_frame_done;
  logic              r_overrun;

  assign w_edge     = vsync_in & ~r_vsync_q;
  assign w_idle_pix = ~raster_busy_in & ~pix_valid_in;
  assign w_swap     = (r_state == S_DONE) && w_edge;

  rsched_clear_gen u_clear_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_start  (w_clr_start),
    .o_busy   (w_clr_busy),
    .o_addr   (w_clr_addr),
    .o_last_c (w_clr_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_clr_start = 1'b0;
    unique case (r_state)
      S_IDLE: if (w_edge) begin
        w_state_nxt = S_CLEAR;
        w_clr_start = 1'b1;
      end
      S_CLEAR:  if (w_clr_last) w_state_nxt = S_LAUNCH;
      S_LAUNCH: w_state_nxt = S_RENDER;
      S_RENDER: if (w_idle_pix && (r_quiet == QUIETW'(QUIET_CYC - 1))) w_state_nxt = S_DONE;
      S_DONE: if (w_edge) begin
        w_state_nxt = S_CLEAR;
        w_clr_start = 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Write port and status outputs; only one state ever drives the write port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vsync_q      <= 1'b0;
      r_quiet        <= '0;
      r_front_bank   <= 1'b0;
      r_wr_en        <= 1'b0;
      r_wr_addr      <= '0;
      r_wr_data      <= '0;
      r_render_start <= 1'b0;
      r_frame_done   <= 1'b0;
      r_overrun      <= 1'b0;
    end else begin
      r_vsync_q      <= vsync_in;
      r_wr_en        <= 1'b0;
      r_render_start <= (r_state == S_LAUNCH);
      r_frame_done   <= (w_state_nxt == S_DONE);
      r_overrun      <= w_edge && ((r_state == S_CLEAR) || (r_state == S_LAUNCH) ||
                                   (r_state == S_RENDER));
      if (w_swap) r_front_bank <= ~r_front_bank;
      if (r_state == S_CLEAR) begin
        r_wr_en   <= w_clr_busy;
        r_wr_addr <= {~r_front_bank, w_clr_addr};
        r_wr_data <= BG_COLOR;
      end else if ((r_state == S_RENDER) && pix_valid_in) begin
        r_wr_en   <= 1'b1;
        r_wr_addr <= {~r_front_bank, pix_addr_in};
        r_wr_data <= pix_color_in;
      end
      if ((r_state == S_RENDER) && w_idle_pix) r_quiet <= r_quiet + QUIETW'(1);
      else                                     r_quiet <= '0;
    end
  end

`ifdef RSCHED_STATS_EN
  logic [STATW-1:0] r_frame_count;
  logic [STATW-1:0] r_drop_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_count <= '0;
      r_drop_count  <= '0;
    end else begin
      if (w_swap) r_frame_count <= sat_inc(r_frame_count);
      if (pix_valid_in && (r_state != S_RENDER)) r_drop_count <= sat_inc(r_drop_count);
    end
  end

  assign frame_count_out = r_frame_count;
  assign drop_count_out  = r_drop_count;
`else
  assign frame_count_out = STATW'(16'h0);
  assign drop_count_out  = STATW'(16'h0);
`endif

  assign render_start_out = r_render_start;
  assign wr_en_out        = r_wr_en;
  assign wr_addr_out      = r_wr_addr;
  assign wr_data_out      = r_wr_data;
  assign front_bank_out   = r_front_bank;
  assign frame_done_out   = r_frame_done;
  assign overrun_out      = r_overrun;

endmodule
